// File: rtl/fetch_queue.sv
// Instruction prefetch queue between fetch and decode: circular buffer of {instr, pc} pairs.
// Optional same-cycle bypass when empty is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_valid,
    input  logic [9:0]    push_instr,
    input  logic [9:0]    push_pc,
    input  logic          flush,
    input  logic          dec_ready,
    output logic          dec_valid,
    output logic [9:0]    dec_instr,
    output logic [9:0]    dec_pc,
    output logic          stall_fetch,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [9:0]    mem_instr [DEPTH];
    logic [9:0]    mem_pc    [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    logic empty;
    logic head_valid;
    logic bypass;
    logic pop;
    logic push;

    assign empty      = (count == '0);
    assign head_valid = ~empty & ~flush;

`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue with a ready decoder: hand the fetched word straight through.
    assign bypass = empty & push_valid & ~flush & dec_ready;
`else
    assign bypass = 1'b0;
`endif

    assign pop         = head_valid & dec_ready;
    assign push        = push_valid & ~flush & ~bypass & ((count < FULL_CNT) | pop);
    assign stall_fetch = (count == FULL_CNT) & ~(dec_ready & dec_valid);

    always_comb begin
        dec_valid = head_valid | bypass;
        dec_instr = '0;
        dec_pc    = '0;
        if (bypass) begin
            dec_instr = push_instr;
            dec_pc    = push_pc;
        end else if (head_valid) begin
            dec_instr = mem_instr[rd_ptr];
            dec_pc    = mem_pc[rd_ptr];
        end
    end

    // Storage needs no reset: entries are only visible while count is nonzero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= push_instr;
            mem_pc[wr_ptr]    <= push_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count <= count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios then random traffic,
// all compared every cycle against a queue-based reference model.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk;
    logic          reset;
    logic          push_valid;
    logic [9:0]    push_instr;
    logic [9:0]    push_pc;
    logic          flush;
    logic          dec_ready;
    logic          dec_valid;
    logic [9:0]    dec_instr;
    logic [9:0]    dec_pc;
    logic          stall_fetch;
    logic [CW-1:0] count;

    fetch_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .push_valid  (push_valid),
        .push_instr  (push_instr),
        .push_pc     (push_pc),
        .flush       (flush),
        .dec_ready   (dec_ready),
        .dec_valid   (dec_valid),
        .dec_instr   (dec_instr),
        .dec_pc      (dec_pc),
        .stall_fetch (stall_fetch),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // Reference model: entries held as {instr, pc}, head at index 0.
    logic [19:0] model_q[$];
    bit          model_known = 1'b0;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic pv, input logic [9:0] ins,
                       input logic [9:0] p, input logic fl, input logic rdy);
        bit          byp_now;
        bit          exp_dv;
        bit          exp_stall;
        bit          do_pop;
        bit          do_push;
        logic [19:0] exp_data;
        @(negedge clk);
        reset      = r;
        push_valid = pv;
        push_instr = ins;
        push_pc    = p;
        flush      = fl;
        dec_ready  = rdy;
        #1;
        byp_now   = BYP && (model_q.size() == 0) && pv && !fl && rdy;
        exp_dv    = byp_now || (model_q.size() != 0 && !fl);
        exp_data  = byp_now ? {ins, p} : (exp_dv ? model_q[0] : 20'h0);
        exp_stall = (model_q.size() == DEPTH) && !(rdy && exp_dv);
        if (model_known) begin
            chk("dec_valid",   {9'h0, dec_valid},   {9'h0, exp_dv});
            chk("dec_instr",   dec_instr,           exp_data[19:10]);
            chk("dec_pc",      dec_pc,              exp_data[9:0]);
            chk("stall_fetch", {9'h0, stall_fetch}, {9'h0, exp_stall});
            chk("count",       {7'h0, count},       10'(model_q.size()));
        end
        @(posedge clk);
        if (r || fl) begin
            model_q.delete();
        end else if (!byp_now) begin
            do_pop  = exp_dv && rdy;
            do_push = pv && (model_q.size() < DEPTH || do_pop);
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back({ins, p});
        end
        if (r) model_known = 1'b1;
    endtask

    initial begin
        reset = 1'b1; push_valid = 1'b0; push_instr = '0; push_pc = '0;
        flush = 1'b0; dec_ready = 1'b0;

        // Reset then in-order delivery
        cyc(1, 0, 10'h000, 10'h000, 0, 1);
        cyc(1, 0, 10'h000, 10'h000, 0, 1);
        cyc(0, 1, 10'h155, 10'h000, 0, 1);
        cyc(0, 1, 10'h2AA, 10'h001, 0, 1);
        cyc(0, 1, 10'h3FF, 10'h002, 0, 1);
        cyc(0, 0, 10'h000, 10'h000, 0, 1);
        cyc(0, 0, 10'h000, 10'h000, 0, 1);

        // Fill and back-pressure: fifth push dropped
        for (int i = 0; i < 5; i++) cyc(0, 1, 10'(10'h100 + i), 10'(10'h010 + i), 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 10'h000, 10'h000, 0, 1);

        // Full with simultaneous push and pop, pointers wrap
        for (int i = 0; i < 4; i++) cyc(0, 1, 10'(10'h200 + i), 10'(10'h020 + i), 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 1, 10'(10'h240 + i), 10'(10'h060 + i), 0, 1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 10'h000, 10'h000, 0, 1);

        // Flush drops queued entries and the same-cycle push
        for (int i = 0; i < 3; i++) cyc(0, 1, 10'(10'h300 + i), 10'(10'h030 + i), 0, 0);
        cyc(0, 1, 10'h0AB, 10'h0AB, 1, 0);
        cyc(0, 1, 10'h0CD, 10'h040, 0, 0);
        cyc(0, 0, 10'h000, 10'h000, 0, 1);
        cyc(0, 0, 10'h000, 10'h000, 0, 1);

        // Reset and flush together while full
        for (int i = 0; i < 4; i++) cyc(0, 1, 10'(10'h380 + i), 10'(10'h050 + i), 0, 0);
        cyc(1, 0, 10'h000, 10'h000, 1, 0);
        cyc(0, 0, 10'h000, 10'h000, 0, 0);

        // Stall hold: head stable while decode is not ready
        cyc(0, 1, 10'h1E1, 10'h071, 0, 0);
        cyc(0, 1, 10'h1E2, 10'h072, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 10'h000, 10'h000, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 10'h000, 10'h000, 0, 1);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            cyc($urandom_range(0, 99) == 0,
                $urandom_range(0, 3) != 0,
                10'($urandom), 10'($urandom),
                $urandom_range(0, 24) == 0,
                $urandom_range(0, 2) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
